// File: rtl/pes_seqgen_pkg.sv
// Shared types, defaults and the length-clamp helper for the pes_seqgen serial transmitter.
package pes_seqgen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        GAP_ST = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 8;
    localparam int GAP_DEF   = 1;
    localparam int REP_W_DEF = 4;

    // Lengths beyond the shifter width are truncated to the full width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/pes_piso_shreg.sv
// Parallel-in serial-out shift register; a load left-justifies the low len bits so the MSB output
// presents frame bit len-1 first.
module pes_piso_shreg
    import pes_seqgen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             ser_out
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data << (LEN_W'(WIDTH) - load_len);
        end else if (shift_en) begin
            shreg_d = shreg_q << 1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign ser_out = shreg_q[WIDTH-1];

endmodule

// File: rtl/pes_seqgen.sv
// Serial frame transmitter: accepts a parallel frame on a valid/ready port and shifts it out
// MSB-first, optionally repeating it with a zero gap between repetitions.
//
//  state  | meaning
//  IDLE   | line held at 0, waiting for a frame
//  SHIFT  | frame bits on sequence_out, one per clock
//  GAP_ST | zero bits between repetitions
module pes_seqgen
    import pes_seqgen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GAP   = GAP_DEF,
    parameter int REP_W = REP_W_DEF,
    localparam int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_repeat,
    output logic             sequence_out,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_GAP   = GAP_ST;

    localparam int GAP_CW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_INIT_I = (GAP > 0) ? GAP - 1 : 0;

    logic [1:0]       state_q,   state_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] frame_q,   frame_d;
    logic [LEN_W-1:0] len_q,     len_d;

    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_data;
    logic [LEN_W-1:0] sh_len;
    logic             ser_bit;

    logic             last_bit;
    logic             accept;
    logic             new_start;
    logic [LEN_W-1:0] len_c;

    assign len_c     = LEN_W'(clamp_len(32'(load_len), WIDTH));
    assign last_bit  = (state_q == S_SHIFT) && (bit_cnt_q == '0);
    assign load_ready = (state_q == S_IDLE) || (last_bit && (rep_cnt_q == '0));
    assign accept    = load_valid && load_ready;
    // A zero-length frame completes the handshake but never leaves IDLE.
    assign new_start = accept && (len_c != '0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        frame_d   = frame_q;
        len_d     = len_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_data   = frame_q;
        sh_len    = len_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    sh_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q - LEN_W'(1);
                end else if (rep_cnt_q != '0) begin
                    rep_cnt_d = rep_cnt_q - REP_W'(1);
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_CW'(GAP_INIT_I);
                    end else begin
                        sh_load   = 1'b1;
                        bit_cnt_d = len_q - LEN_W'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d   = S_SHIFT;
                    sh_load   = 1'b1;
                    bit_cnt_d = len_q - LEN_W'(1);
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // new_start is only possible in IDLE or on the final bit, so it overrides the exit to IDLE.
        if (new_start) begin
            state_d   = S_SHIFT;
            frame_d   = load_data;
            len_d     = len_c;
            rep_cnt_d = load_repeat;
            bit_cnt_d = len_c - LEN_W'(1);
            sh_load   = 1'b1;
            sh_data   = load_data;
            sh_len    = len_c;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            frame_q   <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            frame_q   <= frame_d;
            len_q     <= len_d;
        end
    end

    pes_piso_shreg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clock     (clock),
        .reset     (reset),
        .load      (sh_load),
        .shift_en  (sh_shift),
        .load_data (sh_data),
        .load_len  (sh_len),
        .ser_out   (ser_bit)
    );

    assign sequence_out = (state_q == S_SHIFT) && ser_bit;
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = last_bit;

endmodule
